timer_bank: RTL and testbench
=============================

Name: timer_bank

Overview:
- Parametrised, memory-mapped multi-channel timer peripheral.
- Generalises the fixed single 10 kHz free-running timer into a shared prescaler, a global timebase, and NUM_CH channels with compare, auto-reload, sticky match flags and an interrupt line.
- Sits beside RAM on the memory-stage bus and is decoded by address range.

Parameters:
- NUM_CH, 4: number of timer channels (1..8).
- WIDTH, 32: counter, compare and timebase width (8..32); register reads are zero-extended to 32 bits.
- PRESCALE, 10000: clk cycles per tick; must be >= 1, and 1 means a tick every cycle.
- ADDR_W, 8: byte-address width of the local decode.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- i_memr  in  1  read strobe, one cycle.
- i_memw  in  1  write strobe, one cycle.
- i_addr  in  ADDR_W  byte address, word-aligned; addr[1:0] is ignored.
- i_wdata  in  32  write data.
- o_rdata  out  32  read data, registered.
- o_rvalid  out  1  high for one cycle, the cycle after i_memr.
- o_tick  out  1  prescaler tick pulse.
- o_irq  out  1  level interrupt, registered.
- i_capture  in  NUM_CH  capture inputs; present only with TIMER_CAPTURE_EN.

Behaviour:
- Reset: every register, counter, flag, o_rdata, o_rvalid, o_tick and o_irq is 0.
- Prescaler:
  - pcnt counts 0..PRESCALE-1 and then wraps to 0.
  - o_tick is registered and is 1 in the cycle after pcnt wraps.
  - The global timebase increments on each tick and wraps modulo 2^WIDTH.
- Address map (channel c at byte offset 32*c):
  - +0x00 CTRL: bit0 EN, bit1 RELOAD, bit2 IRQEN.
  - +0x04 COUNT.
  - +0x08 COMPARE.
  - +0x0C STATUS: bit0 MATCH, write-1-to-clear.
  - +0x10 CAPTURE, read-only.
  - Offset 32*NUM_CH is TIMEBASE, read-only.
  - Unmapped reads return 0; unmapped writes are ignored.
- Writes to CAPTURE and TIMEBASE are ignored. Writes to COUNT and COMPARE take the low WIDTH bits.
- Channel update, evaluated on a tick when EN=1:
  - If COUNT == COMPARE: MATCH <= 1. Then if RELOAD=1, COUNT <= 0; otherwise EN <= 0 and COUNT holds.
  - Otherwise COUNT <= COUNT + 1, wrapping modulo 2^WIDTH.
- A channel with EN=0 holds its COUNT.
- Simultaneous events in one cycle:
  - A software write to COUNT or CTRL beats the tick update.
  - A MATCH set beats a W1C clear of MATCH.
  - A read sees the value before the update.
- COMPARE = 0 with RELOAD=1 gives a match on every tick.
- o_irq <= OR over c of (MATCH[c] & IRQEN[c]), registered, so one cycle after the flag changes.
- Read latency is one cycle. Back-to-back reads are allowed every cycle.
- i_memr and i_memw asserted in the same cycle: perform both; the read returns the old value.
- rst asserted mid-operation clears all state immediately; no read pulse is produced afterwards.

Optional Feature:
- Macro: TIMER_CAPTURE_EN.
- With the macro defined:
  - i_capture[c] passes through a 2-flop synchroniser plus a rising-edge detector.
  - On a detected edge, CAPTURE[c] <= COUNT[c], the value before any same-cycle tick increment.
  - If the edge coincides with a software write to COUNT, CAPTURE takes the pre-write value.
  - STATUS bit1 CAPF is set on capture and cleared by W1C.
  - CAPF is not routed to o_irq.
- Without the macro:
  - The i_capture port is absent.
  - CAPTURE reads 0 and STATUS bit1 reads 0.
  - No synchroniser flops are synthesised.

Decomposition:
- Shared package (alongside Common) holds:
  - register offset constants: CTRL, COUNT, COMPARE, STATUS, CAPTURE;
  - the channel stride (32) and the CTRL/STATUS bit-index constants;
  - a packed struct for CTRL.
- Sub-module timer_channel:
  - one instance per channel via generate;
  - inputs: tick, write enables and data;
  - outputs: COUNT, COMPARE, CTRL, flags and the irq term.
- The top level holds the prescaler, timebase, address decode, read mux and irq OR.

Test Plan (bench uses PRESCALE=4):
- Reset: hold rst=0 for 3 cycles, then release. All reads return 0, o_irq=0, and the first o_tick appears 4 cycles after release.
- Compare with auto-reload:
  - Stimulus: ch0 COMPARE=3, CTRL=0b111.
  - Required: COUNT reads 0,1,2,3,0 across ticks; MATCH=1 after the 4th tick; o_irq is high one cycle later.
  - Then write STATUS=1: o_irq drops the cycle after the write.
- One-shot: ch1 COMPARE=2, CTRL=0b001 → after the match EN reads 0, COUNT holds at 2, MATCH=1, and o_irq stays 0 because IRQEN=0.
- Wrap: WIDTH=8, ch2 COUNT=0xFE, COMPARE=0x10, EN=1 → COUNT reads 0xFF, then 0x00, with no MATCH.
- Collisions:
  - COUNT write of 0x55 in the tick cycle → reads 0x55.
  - W1C of MATCH in the cycle a new match occurs → MATCH stays 1.
  - Read at offset 32*NUM_CH+4 → returns 0 with o_rvalid=1.
- TIMER_CAPTURE_EN: pulse i_capture[0] while COUNT=5 → CAPTURE reads 5 within 4 cycles, CAPF=1, and a later W1C of 0b10 clears CAPF.

Source files
------------

// File: rtl/timer_bank_pkg.sv
// Shared constants and types for the timer_bank peripheral and its channels.
// Optional input capture is enabled with the TIMER_CAPTURE_EN macro.
package timer_bank_pkg;

  localparam int unsigned CH_STRIDE = 32;

  localparam logic [4:0] OFF_CTRL    = 5'h00;
  localparam logic [4:0] OFF_COUNT   = 5'h04;
  localparam logic [4:0] OFF_COMPARE = 5'h08;
  localparam logic [4:0] OFF_STATUS  = 5'h0C;
  localparam logic [4:0] OFF_CAPTURE = 5'h10;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_RELOAD_BIT  = 1;
  localparam int CTRL_IRQEN_BIT   = 2;
  localparam int STATUS_MATCH_BIT = 0;
  localparam int STATUS_CAPF_BIT  = 1;

  typedef struct packed {
    logic irqen;
    logic reload;
    logic en;
  } ctrl_t;

  function automatic ctrl_t to_ctrl(input logic [2:0] bits);
    ctrl_t c;
    c.en     = bits[CTRL_EN_BIT];
    c.reload = bits[CTRL_RELOAD_BIT];
    c.irqen  = bits[CTRL_IRQEN_BIT];
    return c;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One compare/auto-reload timer channel with sticky MATCH flag.
// With TIMER_CAPTURE_EN it also synchronises a capture input and latches COUNT.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             we_ctrl,
  input  logic             we_count,
  input  logic             we_compare,
  input  logic             we_status,
  input  logic [WIDTH-1:0] wdata,
`ifdef TIMER_CAPTURE_EN
  input  logic             capture_in,
  output logic [WIDTH-1:0] capture,
  output logic             capf,
`endif
  output ctrl_t            ctrl,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] compare,
  output logic             match,
  output logic             irq_term
);

  logic hit;
  assign hit      = tick && ctrl.en && (count == compare);
  assign irq_term = match && ctrl.irqen;

  // NOTE: sequential state uses <= only; later assignments in the block win,
  // which is how software writes override the tick update below.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl    <= '0;
      count   <= '0;
      compare <= '0;
      match   <= 1'b0;
    end else begin
      if (tick && ctrl.en) begin
        if (hit) begin
          if (ctrl.reload) count   <= '0;
          else             ctrl.en <= 1'b0;
        end else begin
          count <= count + WIDTH'(1);
        end
      end
      if (we_ctrl)    ctrl    <= to_ctrl(wdata[2:0]);
      if (we_count)   count   <= wdata;
      if (we_compare) compare <= wdata;
      if (hit)                                       match <= 1'b1;
      else if (we_status && wdata[STATUS_MATCH_BIT]) match <= 1'b0;
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic [2:0] cap_sync;
  logic       cap_edge;
  assign cap_edge = cap_sync[1] && !cap_sync[2];

  // COUNT here is the registered value, i.e. before any same-cycle tick or write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_sync <= '0;
      capture  <= '0;
      capf     <= 1'b0;
    end else begin
      cap_sync <= {cap_sync[1:0], capture_in};
      if (cap_edge) capture <= count;
      if (cap_edge)                                 capf <= 1'b1;
      else if (we_status && wdata[STATUS_CAPF_BIT]) capf <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/timer_bank.sv
// Memory-mapped multi-channel timer: shared prescaler, global timebase,
// NUM_CH timer_channel instances, registered read port and interrupt.
// Optional input capture is enabled with the TIMER_CAPTURE_EN macro.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 10000,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_memr,
  input  logic              i_memw,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
`ifdef TIMER_CAPTURE_EN
  input  logic [NUM_CH-1:0] i_capture,
`endif
  output logic [31:0]       o_rdata,
  output logic              o_rvalid,
  output logic              o_tick,
  output logic              o_irq
);

  localparam int PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PCNT_W-1:0] pcnt;
  logic [WIDTH-1:0]  timebase;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt     <= '0;
      o_tick   <= 1'b0;
      timebase <= '0;
    end else begin
      if (pcnt == PCNT_W'(PRESCALE - 1)) begin
        pcnt   <= '0;
        o_tick <= 1'b1;
      end else begin
        pcnt   <= pcnt + PCNT_W'(1);
        o_tick <= 1'b0;
      end
      if (o_tick) timebase <= timebase + WIDTH'(1);
    end
  end

  // Word-aligned decode: upper bits pick the channel page, low five the register.
  logic [31:0] addr_al;
  logic [26:0] ch_sel;
  logic [4:0]  off;
  assign addr_al = 32'(i_addr) & ~32'h3;
  assign ch_sel  = addr_al[31:5];
  assign off     = addr_al[4:0];

  ctrl_t             ctrl_a    [NUM_CH];
  logic [WIDTH-1:0]  count_a   [NUM_CH];
  logic [WIDTH-1:0]  compare_a [NUM_CH];
  logic              match_a   [NUM_CH];
  logic [NUM_CH-1:0] irq_terms;
`ifdef TIMER_CAPTURE_EN
  logic [WIDTH-1:0]  capture_a [NUM_CH];
  logic              capf_a    [NUM_CH];
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic sel;
    assign sel = i_memw && (ch_sel == 27'(c));

    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick       (o_tick),
      .we_ctrl    (sel && (off == OFF_CTRL)),
      .we_count   (sel && (off == OFF_COUNT)),
      .we_compare (sel && (off == OFF_COMPARE)),
      .we_status  (sel && (off == OFF_STATUS)),
      .wdata      (i_wdata[WIDTH-1:0]),
`ifdef TIMER_CAPTURE_EN
      .capture_in (i_capture[c]),
      .capture    (capture_a[c]),
      .capf       (capf_a[c]),
`endif
      .ctrl       (ctrl_a[c]),
      .count      (count_a[c]),
      .compare    (compare_a[c]),
      .match      (match_a[c]),
      .irq_term   (irq_terms[c])
    );
  end

  // Upper write-data bits are unused when WIDTH < 32.
  logic unused_wdata;
  assign unused_wdata = ^i_wdata;

  logic [31:0] rd_next;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    rd_next = '0;
    if (addr_al == 32'(CH_STRIDE * NUM_CH)) rd_next = 32'(timebase);
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel == 27'(c)) begin
        case (off)
          OFF_CTRL:    rd_next = {29'b0, ctrl_a[c]};
          OFF_COUNT:   rd_next = 32'(count_a[c]);
          OFF_COMPARE: rd_next = 32'(compare_a[c]);
`ifdef TIMER_CAPTURE_EN
          OFF_STATUS:  rd_next = {30'b0, capf_a[c], match_a[c]};
          OFF_CAPTURE: rd_next = 32'(capture_a[c]);
`else
          OFF_STATUS:  rd_next = {31'b0, match_a[c]};
`endif
          default:     rd_next = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_rdata  <= '0;
      o_rvalid <= 1'b0;
      o_irq    <= 1'b0;
    end else begin
      o_rvalid <= i_memr;
      if (i_memr) o_rdata <= rd_next;
      o_irq <= |irq_terms;
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: directed scenarios plus random bus
// traffic, checked against a behavioural register-level model.
module tb_timer_bank;

  localparam int NUM_CH   = 4;
  localparam int WIDTH    = 8;
  localparam int PRESCALE = 4;
  localparam int ADDR_W   = 8;
  localparam int MASK     = (1 << WIDTH) - 1;
  localparam int TB_ADDR  = 32 * NUM_CH;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_memr = 1'b0;
  logic              i_memw = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic [31:0]       i_wdata = '0;
  logic [31:0]       o_rdata;
  logic              o_rvalid;
  logic              o_tick;
  logic              o_irq;
`ifdef TIMER_CAPTURE_EN
  logic [NUM_CH-1:0] i_capture = '0;
`endif

  timer_bank #(
    .NUM_CH(NUM_CH), .WIDTH(WIDTH), .PRESCALE(PRESCALE), .ADDR_W(ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_memr   (i_memr),
    .i_memw   (i_memw),
    .i_addr   (i_addr),
    .i_wdata  (i_wdata),
`ifdef TIMER_CAPTURE_EN
    .i_capture(i_capture),
`endif
    .o_rdata  (o_rdata),
    .o_rvalid (o_rvalid),
    .o_tick   (o_tick),
    .o_irq    (o_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: register contents, with ticks derived from cycles since reset.
  int m_cyc;
  bit m_en[NUM_CH], m_rl[NUM_CH], m_ie[NUM_CH], m_match[NUM_CH], m_capf[NUM_CH];
  int m_count[NUM_CH], m_cmp[NUM_CH], m_cap[NUM_CH];
  int m_tb;
  bit m_irq;

  function automatic void model_reset();
    m_cyc = 0; m_tb = 0; m_irq = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_en[c] = 0; m_rl[c] = 0; m_ie[c] = 0; m_match[c] = 0; m_capf[c] = 0;
      m_count[c] = 0; m_cmp[c] = 0; m_cap[c] = 0;
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [ADDR_W-1:0] a);
    int aa, ch, off;
    aa = int'(a) & 'hFC;
    ch = aa / 32;
    off = aa % 32;
    if (aa == TB_ADDR) return 32'(m_tb);
    if (ch >= NUM_CH) return 32'h0;
    case (off)
      'h00: return {29'b0, m_ie[ch], m_rl[ch], m_en[ch]};
      'h04: return 32'(m_count[ch]);
      'h08: return 32'(m_cmp[ch]);
      'h0C: return {30'b0, m_capf[ch], m_match[ch]};
      'h10: return 32'(m_cap[ch]);
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_step(input bit w, input logic [ADDR_W-1:0] a,
                                     input logic [31:0] d);
    bit tick;
    int aa, ch, off;
    tick = (m_cyc > 0) && (m_cyc % PRESCALE == 0);
    aa = int'(a) & 'hFC;
    ch = aa / 32;
    off = aa % 32;
    m_irq = 0;
    for (int c = 0; c < NUM_CH; c++) if (m_match[c] && m_ie[c]) m_irq = 1;
    for (int c = 0; c < NUM_CH; c++) begin
      bit hit, wr;
      hit = tick && m_en[c] && (m_count[c] == m_cmp[c]);
      wr  = w && (ch == c);
      if (tick && m_en[c]) begin
        if (hit) begin
          if (m_rl[c]) m_count[c] = 0;
          else         m_en[c] = 0;
        end else begin
          m_count[c] = (m_count[c] + 1) & MASK;
        end
      end
      if (wr && off == 'h00) begin
        m_en[c] = d[0]; m_rl[c] = d[1]; m_ie[c] = d[2];
      end
      if (wr && off == 'h04) m_count[c] = int'(d) & MASK;
      if (wr && off == 'h08) m_cmp[c] = int'(d) & MASK;
      if (wr && off == 'h0C) begin
        if (d[0]) m_match[c] = 0;
        if (d[1]) m_capf[c] = 0;
      end
      if (hit) m_match[c] = 1;
    end
    if (tick) m_tb = (m_tb + 1) & MASK;
    m_cyc++;
  endfunction

  function automatic logic [ADDR_W-1:0] ra(input int ch, input int off);
    return ADDR_W'(ch * 32 + off);
  endfunction

  // One bus cycle: drive at negedge, model advances at posedge, check at next negedge.
  task automatic bus(input bit r, input bit w, input logic [ADDR_W-1:0] a,
                     input logic [31:0] d);
    logic [31:0] exp_rd;
    i_memr = r; i_memw = w; i_addr = a; i_wdata = d;
    exp_rd = model_read(a);
    @(posedge clk);
    model_step(w, a, d);
    @(negedge clk);
    i_memr = 1'b0; i_memw = 1'b0;
    check("rvalid", 32'(o_rvalid), 32'(r));
    if (r) check($sformatf("rd@%02h", a), o_rdata, exp_rd);
    check("tick", 32'(o_tick), 32'(m_cyc % PRESCALE == 0));
    check("irq", 32'(o_irq), 32'(m_irq));
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    bus(1'b0, 1'b1, a, d);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    bus(1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b0, 1'b0, '0, 32'h0);
  endtask

  // Idles until the next bus cycle is one in which a tick is being applied.
  task automatic align_tick();
    for (int i = 0; i < PRESCALE + 1; i++)
      if (!((m_cyc > 0) && (m_cyc % PRESCALE == 0))) idle(1);
  endtask

  task automatic read_all();
    for (int c = 0; c < NUM_CH; c++)
      for (int o = 0; o <= 'h10; o += 4) rd(ra(c, o));
    rd(ADDR_W'(TB_ADDR));
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_rdata", o_rdata, 32'h0);
    check("rst_rvalid", 32'(o_rvalid), 32'h0);
    check("rst_irq", 32'(o_irq), 32'h0);
    check("rst_tick", 32'(o_tick), 32'h0);
    rst = 1'b1;
    read_all();

    // Auto-reload with interrupt on channel 0.
    wr(ra(0, 'h08), 32'd3);
    wr(ra(0, 'h00), 32'b111);
    for (int i = 0; i < 24; i++) rd(ra(0, 'h04));
    check("ar_irq_high", 32'(o_irq), 32'h1);
    wr(ra(0, 'h00), 32'h0);
    wr(ra(0, 'h0C), 32'h1);
    idle(1);
    check("ar_irq_cleared", 32'(o_irq), 32'h0);

    // One-shot on channel 1 without interrupt enable.
    wr(ra(1, 'h08), 32'd2);
    wr(ra(1, 'h00), 32'b001);
    idle(20);
    rd(ra(1, 'h00)); check("os_ctrl", o_rdata, 32'h0);
    rd(ra(1, 'h04)); check("os_count", o_rdata, 32'h2);
    rd(ra(1, 'h0C)); check("os_match", o_rdata, 32'h1);
    check("os_no_irq", 32'(o_irq), 32'h0);

    // Counter wrap on channel 2.
    wr(ra(2, 'h04), 32'hFE);
    wr(ra(2, 'h08), 32'h10);
    wr(ra(2, 'h00), 32'b001);
    for (int i = 0; i < 10; i++) rd(ra(2, 'h04));
    rd(ra(2, 'h0C)); check("wrap_no_match", o_rdata, 32'h0);
    wr(ra(2, 'h00), 32'h0);

    // COUNT write in a tick cycle beats the increment.
    wr(ra(3, 'h08), 32'h80);
    wr(ra(3, 'h00), 32'b001);
    align_tick();
    wr(ra(3, 'h04), 32'h55);
    rd(ra(3, 'h04)); check("col_count", o_rdata, 32'h55);

    // MATCH set beats a same-cycle W1C.
    wr(ra(0, 'h08), 32'h0);
    wr(ra(0, 'h04), 32'h0);
    wr(ra(0, 'h00), 32'b011);
    idle(PRESCALE + 1);
    align_tick();
    wr(ra(0, 'h0C), 32'h1);
    rd(ra(0, 'h0C)); check("col_w1c", o_rdata, 32'h1);

    // Unmapped read, simultaneous read+write, ignored read-only writes.
    rd(ADDR_W'(TB_ADDR + 4)); check("unmapped", o_rdata, 32'h0);
    bus(1'b1, 1'b1, ra(3, 'h08), 32'h22); check("rw_old", o_rdata, 32'h80);
    rd(ra(3, 'h08)); check("rw_new", o_rdata, 32'h22);
    wr(ra(1, 'h10), 32'hAB);
    wr(ADDR_W'(TB_ADDR), 32'hAB);
    read_all();

`ifdef TIMER_CAPTURE_EN
    wr(ra(0, 'h00), 32'h0);
    wr(ra(0, 'h04), 32'd5);
    wr(ra(0, 'h0C), 32'h3);
    i_capture[0] = 1'b1;
    idle(1);
    i_capture[0] = 1'b0;
    idle(3);
    m_cap[0] = 5;
    m_capf[0] = 1;
    rd(ra(0, 'h10)); check("cap_value", o_rdata, 32'h5);
    rd(ra(0, 'h0C)); check("cap_flag", o_rdata, 32'h2);
    wr(ra(0, 'h0C), 32'h2);
    rd(ra(0, 'h0C)); check("cap_clear", o_rdata, 32'h0);
`endif

    // Random traffic with small compare values so matches are frequent.
    for (int i = 0; i < 400; i++) begin
      int ch, off, kind;
      logic [31:0] d;
      ch   = $urandom_range(0, NUM_CH);
      off  = 4 * $urandom_range(0, 5);
      kind = $urandom_range(0, 3);
      case (off)
        'h00:    d = 32'($urandom_range(0, 7));
        'h0C:    d = 32'($urandom_range(0, 3));
        'h04,
        'h08:    d = 32'($urandom_range(0, 12));
        default: d = $urandom;
      endcase
      bus(kind[0], kind[1], ra(ch, off), d);
    end

    // Reset asserted together with a read: no read pulse follows.
    i_memr = 1'b1; i_addr = ra(0, 'h04); rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_rvalid", 32'(o_rvalid), 32'h0);
    check("mid_rst_rdata", o_rdata, 32'h0);
    check("mid_rst_irq", 32'(o_irq), 32'h0);
    i_memr = 1'b0;
    rst = 1'b1;
    model_reset();
    read_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
